// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, next-PC select, req/ack imem port, one-entry skid buffer, IF/ID register.
// Define BRANCH_DELAY_SLOT_EN to keep the word fetched after a redirect; otherwise it is squashed.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] pc
);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic SQUASH_SLOT = 1'b0;
`else
    localparam logic SQUASH_SLOT = 1'b1;
`endif

    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t      state;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc4;
    logic        skid_squash;
    logic [31:0] redir_pend;
    logic        redir_flag;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        redirect;
    logic        fetch_squash;
    logic        hold_squash;

    assign imem_addr = pc;

    always_comb begin
        pc_plus4 = pc + 32'd4;
        redirect = if_id_valid & (pcsource != 2'b00) & ~stall;
        case (pcsource)
            2'b01:   target = bpc;
            2'b10:   target = rpc;
            2'b11:   target = jpc;
            default: target = pc_plus4;
        endcase
        // The word behind a redirecting instruction is either in flight or parked in the skid buffer.
        fetch_squash = (redirect | redir_flag) & SQUASH_SLOT;
        hold_squash  = (redirect | skid_squash) & SQUASH_SLOT;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            if_id_inst  <= NOP_INST;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            skid_inst   <= NOP_INST;
            skid_pc4    <= '0;
            skid_squash <= 1'b0;
            redir_pend  <= '0;
            redir_flag  <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end

                FETCH: begin
                    if (imem_ack) begin
                        if (!stall) begin
                            if (fetch_squash) begin
                                if_id_inst  <= NOP_INST;
                                if_id_valid <= 1'b0;
                            end else begin
                                if_id_inst  <= imem_rdata;
                                if_id_valid <= 1'b1;
                            end
                            if_id_pc4 <= pc_plus4;
                            if (redirect)
                                pc <= target;
                            else if (redir_flag)
                                pc <= redir_pend;
                            else
                                pc <= pc_plus4;
                        end else begin
                            skid_inst   <= imem_rdata;
                            skid_pc4    <= pc_plus4;
                            skid_squash <= redir_flag;
                            pc          <= redir_flag ? redir_pend : pc_plus4;
                            state       <= HOLD;
                            imem_req    <= 1'b0;
                        end
                        redir_flag <= 1'b0;
                    end else if (!stall) begin
                        // Address must stay put until ack, so the target waits in redir_pend.
                        if_id_inst  <= NOP_INST;
                        if_id_valid <= 1'b0;
                        if (redirect) begin
                            redir_pend <= target;
                            redir_flag <= 1'b1;
                        end
                    end
                end

                HOLD: begin
                    if (!stall) begin
                        if (hold_squash) begin
                            if_id_inst  <= NOP_INST;
                            if_id_valid <= 1'b0;
                        end else begin
                            if_id_inst  <= skid_inst;
                            if_id_valid <= 1'b1;
                        end
                        if_id_pc4   <= skid_pc4;
                        if (redirect)
                            pc <= target;
                        skid_squash <= 1'b0;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                    end
                end

                default: begin
                    state    <= BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
